// File: rtl/hazard_pkg.sv
// Shared encodings and width helpers for the ID-stage hazard scoreboard.
package hazard_pkg;

  // A forward select of zero means the operand comes from the register file.
  localparam int unsigned FWD_RF = 0;

  // Register address width. A single-register file still gets one address bit.
  function automatic int unsigned aw_f(input int unsigned num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

  // Forward select width. It must be able to encode every age from 0 to wb_lat.
  function automatic int unsigned sw_f(input int unsigned wb_lat);
    return $clog2(wb_lat + 1);
  endfunction

endpackage

// File: rtl/hazard_src_check.sv
// Per-source hazard check. Finds the youngest in-flight writer of the addressed
// register and decides whether its result can be forwarded yet or ID must stall.
module hazard_src_check
  import hazard_pkg::*;
#(
  parameter int unsigned WB_LAT     = 3,
  parameter int unsigned ALU_READY  = 1,
  parameter int unsigned LOAD_READY = 2,
  parameter int unsigned FWD_EN     = 1,
  parameter int unsigned SW         = sw_f(WB_LAT)
) (
  input  logic              i_used,
  input  logic [WB_LAT:1]   i_pend,
  input  logic [WB_LAT:1]   i_ld,
  output logic              o_stall,
  output logic [SW-1:0]     o_sel
);

  logic        w_hit;
  logic        w_is_ld;
  int unsigned w_age;

  // Priority encoder. The scan runs from oldest to youngest, so the lowest age wins.
  always_comb begin
    w_hit   = 1'b0;
    w_is_ld = 1'b0;
    w_age   = 0;
    for (int k = WB_LAT; k >= 1; k--) begin
      if (i_pend[k]) begin
        w_hit   = 1'b1;
        w_is_ld = i_ld[k];
        w_age   = k;
      end
    end
  end

  // Readiness compare and bypass selection for the youngest writer.
  always_comb begin
    o_stall = 1'b0;
    o_sel   = SW'(FWD_RF);
    if (i_used && w_hit) begin
      if (FWD_EN != 0) begin
        o_stall = (w_age < (w_is_ld ? LOAD_READY : ALU_READY));
        // The regfile is write-first in WB, so a WB-age writer needs no bypass.
        if (w_age != WB_LAT) begin
          o_sel = SW'(w_age);
        end
      end else begin
        o_stall = (w_age < WB_LAT);
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard. It tracks in-flight writers per register by pipeline
// age, and from that produces the stall and forward selects for both ID sources.
// It also honours flushes and counts stall cycles.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 4,
  parameter int unsigned WB_LAT     = 3,
  parameter int unsigned ALU_READY  = 1,
  parameter int unsigned LOAD_READY = 2,
  parameter int unsigned FWD_EN     = 1,
  parameter int unsigned FLUSH_AGE  = 1,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned AW         = aw_f(NUM_REGS),
  parameter int unsigned SW         = sw_f(WB_LAT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_id_valid,
  input  logic             i_id_a_used,
  input  logic [AW-1:0]    i_id_a_addr,
  input  logic             i_id_b_used,
  input  logic [AW-1:0]    i_id_b_addr,
  input  logic             i_id_dst_we,
  input  logic [AW-1:0]    i_id_dst_addr,
  input  logic             i_id_is_load,
  input  logic             i_flush,
  output logic             o_stall,
  output logic             o_issue,
  output logic [SW-1:0]    o_fwd_a_sel,
  output logic [SW-1:0]    o_fwd_b_sel,
  output logic [CNT_W-1:0] o_stall_cnt
);

  // Bit k of a row is set while a writer of that register sits at age k.
  logic [WB_LAT:1]  r_pend [NUM_REGS];
  logic [WB_LAT:1]  r_ld   [NUM_REGS];
  logic [WB_LAT:1]  w_pend_d [NUM_REGS];
  logic [WB_LAT:1]  w_ld_d   [NUM_REGS];
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] w_stall_cnt_d;

  logic             w_stall_a;
  logic             w_stall_b;
  logic             w_insert;

  hazard_src_check #(
    .WB_LAT     (WB_LAT),
    .ALU_READY  (ALU_READY),
    .LOAD_READY (LOAD_READY),
    .FWD_EN     (FWD_EN),
    .SW         (SW)
  ) u_src_a (
    .i_used  (i_id_a_used),
    .i_pend  (r_pend[i_id_a_addr]),
    .i_ld    (r_ld[i_id_a_addr]),
    .o_stall (w_stall_a),
    .o_sel   (o_fwd_a_sel)
  );

  hazard_src_check #(
    .WB_LAT     (WB_LAT),
    .ALU_READY  (ALU_READY),
    .LOAD_READY (LOAD_READY),
    .FWD_EN     (FWD_EN),
    .SW         (SW)
  ) u_src_b (
    .i_used  (i_id_b_used),
    .i_pend  (r_pend[i_id_b_addr]),
    .i_ld    (r_ld[i_id_b_addr]),
    .o_stall (w_stall_b),
    .o_sel   (o_fwd_b_sel)
  );

  // Issue control. A flush overrides the stall and blocks the ID instruction.
  always_comb begin
    o_stall  = i_id_valid & ~i_flush & (w_stall_a | w_stall_b);
    o_issue  = i_id_valid & ~o_stall & ~i_flush;
    w_insert = o_issue & i_id_dst_we;
  end

  // Age every writer by one stage. A flush kills the young ones, and age 1 takes the new writer.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      w_pend_d[r] = '0;
      w_ld_d[r]   = '0;
      for (int k = 1; k < WB_LAT; k++) begin
        w_pend_d[r][k+1] = r_pend[r][k] & ~(i_flush && (k <= FLUSH_AGE));
        w_ld_d[r][k+1]   = r_ld[r][k]   & ~(i_flush && (k <= FLUSH_AGE));
      end
      w_pend_d[r][1] = w_insert & (i_id_dst_addr == AW'(r));
      w_ld_d[r][1]   = w_insert & (i_id_dst_addr == AW'(r)) & i_id_is_load;
    end
  end

  // Saturating count of stall cycles.
  always_comb begin
    w_stall_cnt_d = r_stall_cnt;
    if (o_stall && (r_stall_cnt != '1)) begin
      w_stall_cnt_d = r_stall_cnt + 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_pend[r] <= '0;
        r_ld[r]   <= '0;
      end
      r_stall_cnt <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_pend[r] <= w_pend_d[r];
        r_ld[r]   <= w_ld_d[r];
      end
      r_stall_cnt <= w_stall_cnt_d;
    end
  end

  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard. It drives three instances from shared stimulus:
// the default forwarding build, a build with no forwarding, and a build with a 3-bit counter.
module tb_hazard_scoreboard;

  logic       clk;
  logic       rst_n;
  logic       id_valid, a_used, b_used, dst_we, is_load, flush;
  logic [1:0] a_addr, b_addr, dst_addr;

  logic        stall1, issue1, stall2, issue2, stall3, issue3;
  logic [1:0]  fa1, fb1, fa2, fb2, fa3, fb3;
  logic [15:0] cnt1, cnt2;
  logic [2:0]  cnt3;

  int n_vec = 0;
  int n_err = 0;

  hazard_scoreboard u_dut_fwd (
    .clk (clk), .rst_n (rst_n), .i_id_valid (id_valid),
    .i_id_a_used (a_used), .i_id_a_addr (a_addr),
    .i_id_b_used (b_used), .i_id_b_addr (b_addr),
    .i_id_dst_we (dst_we), .i_id_dst_addr (dst_addr), .i_id_is_load (is_load),
    .i_flush (flush), .o_stall (stall1), .o_issue (issue1),
    .o_fwd_a_sel (fa1), .o_fwd_b_sel (fb1), .o_stall_cnt (cnt1)
  );

  hazard_scoreboard #(.FWD_EN (0)) u_dut_nofwd (
    .clk (clk), .rst_n (rst_n), .i_id_valid (id_valid),
    .i_id_a_used (a_used), .i_id_a_addr (a_addr),
    .i_id_b_used (b_used), .i_id_b_addr (b_addr),
    .i_id_dst_we (dst_we), .i_id_dst_addr (dst_addr), .i_id_is_load (is_load),
    .i_flush (flush), .o_stall (stall2), .o_issue (issue2),
    .o_fwd_a_sel (fa2), .o_fwd_b_sel (fb2), .o_stall_cnt (cnt2)
  );

  hazard_scoreboard #(.CNT_W (3)) u_dut_sat (
    .clk (clk), .rst_n (rst_n), .i_id_valid (id_valid),
    .i_id_a_used (a_used), .i_id_a_addr (a_addr),
    .i_id_b_used (b_used), .i_id_b_addr (b_addr),
    .i_id_dst_we (dst_we), .i_id_dst_addr (dst_addr), .i_id_is_load (is_load),
    .i_flush (flush), .o_stall (stall3), .o_issue (issue3),
    .o_fwd_a_sel (fa3), .o_fwd_b_sel (fb3), .o_stall_cnt (cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk_v(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic au, input logic [1:0] aa, input logic bu,
                       input logic [1:0] ba, input logic we, input logic [1:0] da,
                       input logic ld, input logic fl);
    id_valid = v;  a_used = au; a_addr = aa; b_used = bu; b_addr = ba;
    dst_we = we; dst_addr = da; is_load = ld; flush = fl;
    #1;
  endtask

  // Advance one cycle. Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    // Reset state. A valid read of r1 must issue with no stall and no bypass.
    drive(1'b1, 1'b1, 2'd1, 1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0);
    chk_b("rst_stall", stall1, 1'b0);
    chk_b("rst_issue", issue1, 1'b1);
    chk_v("rst_fwd_a", 16'(fa1), 16'd0);
    chk_v("rst_cnt", cnt1, 16'd0);
    idle(2);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // No forwarding: an ALU write of r1, then a read of r1, stalls for 2 cycles.
    drive(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd1, 1'b0, 1'b0);
    chk_b("nofwd_c0_issue", issue2, 1'b1);
    tick();
    drive(1'b1, 1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    chk_b("nofwd_c1_stall", stall2, 1'b1);
    chk_b("nofwd_c1_issue", issue2, 1'b0);
    chk_b("fwd_c1_stall", stall1, 1'b0);
    chk_v("fwd_c1_sel", 16'(fa1), 16'd1);
    tick();
    chk_b("nofwd_c2_stall", stall2, 1'b1);
    tick();
    chk_b("nofwd_c3_stall", stall2, 1'b0);
    chk_b("nofwd_c3_issue", issue2, 1'b1);
    chk_v("nofwd_c3_sel", 16'(fa2), 16'd0);
    chk_v("nofwd_cnt", cnt2, 16'd2);
    tick();
    idle(3);

    // An ALU write of r1 is then read at ages 1, 2 and 3.
    drive(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    chk_b("alu_age1_stall", stall1, 1'b0);
    chk_v("alu_age1_sel", 16'(fa1), 16'd1);
    tick();
    chk_v("alu_age2_sel", 16'(fa1), 16'd2);
    tick();
    chk_b("alu_age3_stall", stall1, 1'b0);
    chk_v("alu_age3_sel", 16'(fa1), 16'd0);
    tick();
    idle(3);

    // Load-use: a load to r2 makes the next read of r2 as source b stall once.
    drive(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd2, 1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0);
    chk_b("ld_c1_stall", stall1, 1'b1);
    chk_b("ld_c1_issue", issue1, 1'b0);
    tick();
    chk_v("ld_c2_cnt", cnt1, 16'd1);
    chk_b("ld_c2_stall", stall1, 1'b0);
    chk_b("ld_c2_issue", issue1, 1'b1);
    chk_v("ld_c2_sel", 16'(fb1), 16'd2);
    tick();
    idle(3);

    // Two writers of r3: the youngest one wins. A source that is not used gets no bypass.
    drive(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd3, 1'b0, 1'b0);
    tick();
    tick();
    drive(1'b1, 1'b1, 2'd3, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    chk_b("young_stall", stall1, 1'b0);
    chk_v("young_sel", 16'(fa1), 16'd1);
    drive(1'b1, 1'b0, 2'd3, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    chk_b("unused_stall", stall1, 1'b0);
    chk_v("unused_sel", 16'(fa1), 16'd0);
    tick();
    idle(3);

    // Flushing the younger r3 writer leaves the older one, which is now in WB.
    drive(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd3, 1'b0, 1'b0);
    tick();
    tick();
    drive(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 1'b1, 2'd3, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    chk_b("reveal_stall", stall1, 1'b0);
    chk_v("reveal_sel", 16'(fa1), 16'd0);
    tick();
    idle(3);

    // A flush kills a load at age 1. A flush that arrives with a live hazard blocks issue.
    drive(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd1, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    chk_b("flushed_stall", stall1, 1'b0);
    chk_v("flushed_sel", 16'(fa1), 16'd0);
    tick();
    drive(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd2, 1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 1'b1);
    chk_b("flush_hz_stall", stall1, 1'b0);
    chk_b("flush_hz_issue", issue1, 1'b0);
    tick();
    drive(1'b1, 1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0);
    chk_b("flush_hz_after_stall", stall1, 1'b0);
    chk_v("flush_hz_after_sel", 16'(fb1), 16'd0);
    chk_v("flush_cnt", cnt1, 16'd1);
    tick();
    idle(3);

    // Four more load-use stalls bring the count to 5. Then an async reset arrives mid-cycle.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b1, 1'b0);
      tick();
      drive(1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
      chk_b("lu_loop_stall", stall1, 1'b1);
      tick();
      idle(1);
    end
    chk_v("cnt_five", cnt1, 16'd5);
    drive(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    chk_b("pre_rst_stall", stall1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_b("async_rst_stall", stall1, 1'b0);
    chk_b("async_rst_issue", issue1, 1'b1);
    chk_v("async_rst_cnt", cnt1, 16'd0);
    @(negedge clk) rst_n = 1'b1;
    idle(1);

    // A back-to-back load that reads its own destination stalls every other cycle.
    drive(1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    chk_v("sat_partial", 16'(cnt3), 16'd3);
    for (int i = 0; i < 14; i++) tick();
    chk_v("sat_full", 16'(cnt3), 16'd7);
    chk_v("wide_cnt", cnt1, 16'd10);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
